// File: rtl/inst_fetch_queue.sv
// In-order instruction response queue between IF and ID; drops responses of pre-redirect requests.
// Optional zero-latency response bypass to ID when INST_QUEUE_BYPASS_EN is defined.
module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int OUTS_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_fire,
  input  logic [31:0]              req_pc,
  input  logic                     req_exc,
  input  logic [5:0]               req_ecode,
  output logic                     can_issue,
  input  logic                     data_ok,
  input  logic [31:0]              rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_has_exc,
  output logic [5:0]               out_ecode,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic        filled;
  } ent_t;

  ent_t          ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] count_q, count_d, unf_q, unf_d;
  logic [3:0]    disc_q, disc_d;
  logic          push, pop, fill_ev, byp;

  assign can_issue = (count_q < CW'(DEPTH)) && ((32'(disc_q) + 32'(unf_q)) < OUTS_MAX);
  assign push      = req_fire && can_issue;
  // A response fills the oldest unfilled entry only when no stale responses remain.
  assign fill_ev   = data_ok && (disc_q == 4'd0) && (unf_q != '0);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp = fill_ev && (count_q != '0) && !ent_q[head_q].filled && (fill_q == head_q);
`else
  assign byp = 1'b0;
`endif

  assign out_valid   = ((count_q != '0) && ent_q[head_q].filled) || byp;
  assign out_pc      = ent_q[head_q].pc;
  assign out_inst    = byp ? rdata : ent_q[head_q].inst;
  assign out_has_exc = ent_q[head_q].exc;
  assign out_ecode   = ent_q[head_q].ecode;
  assign count       = count_q;
  assign pop         = out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    unf_d   = unf_q;
    disc_d  = disc_q;
    if (flush) begin
      // Every outstanding request becomes stale; a response this cycle retires one of them.
      disc_d  = disc_q + 4'(unf_q)
                - 4'((data_ok && (disc_q != 4'd0 || unf_q != '0)) ? 1 : 0);
      head_d  = tail_q;
      fill_d  = tail_q;
      count_d = '0;
      unf_d   = '0;
      if (push) begin
        tail_d  = tail_q + 1'b1;
        count_d = CW'(1);
        unf_d   = CW'(1);
      end
    end else begin
      if (data_ok && disc_q != 4'd0) disc_d = disc_q - 4'd1;
      if (fill_ev) fill_d = fill_q + 1'b1;
      if (pop)     head_d = head_q + 1'b1;
      if (push)    tail_d = tail_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      unf_d   = unf_q + CW'(push) - CW'(fill_ev);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      unf_q   <= '0;
      disc_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      unf_q   <= unf_d;
      disc_q  <= disc_d;
      // fill and tail never alias while a push is possible, so both writes are safe.
      if (fill_ev && !flush) begin
        ent_q[fill_q].inst   <= rdata;
        ent_q[fill_q].filled <= 1'b1;
      end
      if (push) ent_q[tail_q] <= '{pc: req_pc, inst: 32'd0, exc: req_exc,
                                   ecode: req_ecode, filled: 1'b0};
    end
  end
endmodule
